// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display fetcher has priority, CPU protected by a starvation limit.
// Latency: read ack in N+3, write ack in N+2; backpressure: requests held until ack, ignored while busy.
module vram_arbiter #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 8,
    parameter int CPU_STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic [DATA_W-1:0] disp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(CPU_STARVE_MAX);

    state_t     state_q;
    state_t     state_d;
    logic       owner_cpu_q;
    logic       owner_cpu_d;
    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic       grant_cpu;
    logic       grant_disp;

    always_comb begin
        state_d     = state_q;
        owner_cpu_d = owner_cpu_q;
        starve_d    = starve_q;
        grant_cpu   = 1'b0;
        grant_disp  = 1'b0;
        case (state_q)
            IDLE: begin
                // The CPU only overtakes a pending display read once the limit is reached.
                if (cpu_req && (!disp_req || starve_q == STARVE_MAX)) begin
                    grant_cpu = 1'b1;
                end else if (disp_req) begin
                    grant_disp = 1'b1;
                end

                if (grant_cpu || !cpu_req) begin
                    starve_d = 4'd0;
                end else if (grant_disp && starve_q < STARVE_MAX) begin
                    starve_d = starve_q + 4'd1;
                end

                if (grant_cpu || grant_disp) begin
                    state_d     = ISSUE;
                    owner_cpu_d = grant_cpu;
                end
            end
            // ram_we is only ever set during the ISSUE cycle of a CPU write.
            ISSUE:   state_d = ram_we ? DONE : WAIT;
            WAIT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            owner_cpu_q <= 1'b0;
            starve_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            owner_cpu_q <= owner_cpu_d;
            starve_q    <= starve_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            cpu_rdata  <= '0;
            disp_rdata <= '0;
        end else begin
            ram_we <= grant_cpu & cpu_we;
            if (grant_cpu) begin
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_wdata;
            end else if (grant_disp) begin
                ram_addr <= disp_addr;
            end

            // Synchronous RAM returns data the cycle after ISSUE.
            if (state_q == WAIT) begin
                if (owner_cpu_q) begin
                    cpu_rdata <= ram_rdata;
                end else begin
                    disp_rdata <= ram_rdata;
                end
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign cpu_ack  = (state_q == DONE) && owner_cpu_q;
    assign disp_ack = (state_q == DONE) && !owner_cpu_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed handshake/timing steps, then random traffic against a transaction model.
module tb_vram_arbiter;
    localparam int AW   = 11;
    localparam int DW   = 8;
    localparam int SMAX = 4;

    logic          clk;
    logic          n_reset;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_ack;
    logic [DW-1:0] disp_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem     [2**AW];
    logic [DW-1:0] ref_mem [2**AW];
    bit            ram_loaded = 1'b0;

    bit            cpu_pend;
    bit            disp_pend;
    bit            c_we;
    logic [AW-1:0] c_addr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] c_wd;
    logic [DW-1:0] last_cpu;
    logic [DW-1:0] last_disp;
    int            m_starve;
    string         seq;
    bit            got;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_STARVE_MAX(SMAX)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_ack   (disp_ack),
        .disp_rdata (disp_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port RAM: read returns the pre-write contents.
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 2**AW; i++) mem[i] = ref_mem[i];
            ram_loaded = 1'b1;
        end
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] = ram_wdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One arbitration round starting in an IDLE cycle; returns whether the DUT served the CPU.
    task automatic round(input bit force_both, output bit got_cpu);
        bit            win_cpu;
        bit            win_we;
        logic [AW-1:0] waddr;
        int            lat;
        got_cpu = 1'b0;
        if (!cpu_pend && (force_both || $urandom_range(0, 2) != 0)) begin
            cpu_pend = 1'b1;
            c_we     = force_both ? 1'b0 : 1'($urandom_range(0, 1));
            c_addr   = AW'($urandom_range(0, 2**AW - 1));
            c_wd     = DW'($urandom);
            if (disp_pend && c_addr == d_addr) c_addr = c_addr ^ AW'(1);
        end
        if (!disp_pend && (force_both || $urandom_range(0, 2) != 0)) begin
            disp_pend = 1'b1;
            d_addr    = AW'($urandom_range(0, 2**AW - 1));
            if (cpu_pend && c_addr == d_addr) d_addr = d_addr ^ AW'(1);
        end
        cpu_req   = cpu_pend;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wd;
        disp_req  = disp_pend;
        disp_addr = d_addr;

        if (!cpu_pend && !disp_pend) begin
            m_starve = 0;
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
            return;
        end

        win_cpu = cpu_pend && (!disp_pend || m_starve == SMAX);
        if (win_cpu || !cpu_pend) m_starve = 0;
        else if (m_starve < SMAX) m_starve = m_starve + 1;
        win_we = win_cpu && c_we;
        waddr  = win_cpu ? c_addr : d_addr;
        lat    = win_we ? 2 : 3;
        if (win_we) ref_mem[c_addr] = c_wd;

        tick();
        got_cpu = cpu_pend && (ram_addr === c_addr);
        chk("grant_addr", 32'(ram_addr), 32'(waddr));
        chk("grant_we", 32'(ram_we), 32'(win_we));
        if (win_we) chk("grant_wdata", 32'(ram_wdata), 32'(c_wd));
        for (int i = 2; i <= lat; i++) begin
            tick();
            chk("acc_busy", 32'(busy), 32'd1);
            chk("acc_cpu_ack", 32'(cpu_ack), 32'(win_cpu && i == lat));
            chk("acc_disp_ack", 32'(disp_ack), 32'(!win_cpu && i == lat));
        end
        if (win_cpu && !c_we) last_cpu = ref_mem[c_addr];
        if (!win_cpu) last_disp = ref_mem[d_addr];
        chk("cpu_rdata", 32'(cpu_rdata), 32'(last_cpu));
        chk("disp_rdata", 32'(disp_rdata), 32'(last_disp));

        if (win_cpu) begin
            cpu_pend = 1'b0;
            cpu_req  = 1'b0;
        end else begin
            disp_pend = 1'b0;
            disp_req  = 1'b0;
        end
        tick();
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_acks", 32'({cpu_ack, disp_ack}), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = DW'($urandom);
        ref_mem[11'h123] = 8'h41;
        ref_mem[11'h7FF] = 8'h00;
        cpu_pend  = 1'b0;
        disp_pend = 1'b0;
        c_we      = 1'b0;
        c_addr    = '0;
        c_wd      = '0;
        d_addr    = '0;
        m_starve  = 0;

        // Reset with both requests asserted.
        n_reset   = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 11'h001;
        cpu_wdata = 8'hFF;
        disp_req  = 1'b1;
        disp_addr = 11'h002;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_acks", 32'({cpu_ack, disp_ack}), 32'd0);
            chk("rst_we_busy", 32'({ram_we, busy}), 32'd0);
            chk("rst_ram_addr", 32'(ram_addr), 32'd0);
            chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
            chk("rst_rdata", 32'({cpu_rdata, disp_rdata}), 32'd0);
        end
        n_reset  = 1'b1;
        cpu_req  = 1'b0;
        disp_req = 1'b0;
        tick();
        chk("rel_busy", 32'(busy), 32'd0);
        tick();
        chk("rel_busy2", 32'(busy), 32'd0);
        last_cpu  = '0;
        last_disp = '0;

        // Display read of 0x123.
        disp_addr = 11'h123;
        disp_req  = 1'b1;
        tick();
        chk("dr_addr", 32'(ram_addr), 32'h123);
        chk("dr_we1", 32'(ram_we), 32'd0);
        chk("dr_ack1", 32'(disp_ack), 32'd0);
        disp_req = 1'b0;
        tick();
        chk("dr_ack2", 32'(disp_ack), 32'd0);
        chk("dr_we2", 32'(ram_we), 32'd0);
        tick();
        chk("dr_ack3", 32'(disp_ack), 32'd1);
        chk("dr_data", 32'(disp_rdata), 32'h41);
        chk("dr_we3", 32'(ram_we), 32'd0);
        tick();
        chk("dr_ack4", 32'(disp_ack), 32'd0);
        chk("dr_busy4", 32'(busy), 32'd0);
        last_disp = 8'h41;

        // CPU write 0x5A to 0x7FF, then read it back.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 11'h7FF;
        cpu_wdata = 8'h5A;
        tick();
        chk("cw_we", 32'(ram_we), 32'd1);
        chk("cw_addr", 32'(ram_addr), 32'h7FF);
        chk("cw_data", 32'(ram_wdata), 32'h5A);
        chk("cw_ack1", 32'(cpu_ack), 32'd0);
        cpu_req = 1'b0;
        tick();
        chk("cw_we2", 32'(ram_we), 32'd0);
        chk("cw_ack2", 32'(cpu_ack), 32'd1);
        tick();
        chk("cw_ack3", 32'(cpu_ack), 32'd0);
        chk("cw_busy3", 32'(busy), 32'd0);
        ref_mem[11'h7FF] = 8'h5A;
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        tick();
        chk("cr_we1", 32'(ram_we), 32'd0);
        cpu_req = 1'b0;
        tick();
        chk("cr_ack2", 32'(cpu_ack), 32'd0);
        tick();
        chk("cr_ack3", 32'(cpu_ack), 32'd1);
        chk("cr_data", 32'(cpu_rdata), 32'h5A);
        tick();
        last_cpu = 8'h5A;

        // Simultaneous requests: display first, CPU write follows.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 11'h055;
        cpu_wdata = 8'hC3;
        disp_req  = 1'b1;
        disp_addr = 11'h123;
        tick();
        chk("sim_addr1", 32'(ram_addr), 32'h123);
        chk("sim_we1", 32'(ram_we), 32'd0);
        tick();
        tick();
        chk("sim_dack3", 32'(disp_ack), 32'd1);
        chk("sim_cack3", 32'(cpu_ack), 32'd0);
        disp_req = 1'b0;
        tick();
        chk("sim_idle4", 32'(busy), 32'd0);
        tick();
        chk("sim_we5", 32'(ram_we), 32'd1);
        chk("sim_addr5", 32'(ram_addr), 32'h055);
        cpu_req = 1'b0;
        tick();
        chk("sim_cack6", 32'(cpu_ack), 32'd1);
        chk("sim_rdata6", 32'(cpu_rdata), 32'h5A);
        tick();
        ref_mem[11'h055] = 8'hC3;

        // Reset during the ISSUE cycle of a CPU read; CPU keeps requesting.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 11'h123;
        tick();
        n_reset = 1'b0;
        tick();
        chk("mr_ack", 32'(cpu_ack), 32'd0);
        chk("mr_rdata", 32'(cpu_rdata), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_we", 32'(ram_we), 32'd0);
        tick();
        chk("mr_ack2", 32'(cpu_ack), 32'd0);
        n_reset   = 1'b1;
        last_cpu  = '0;
        last_disp = '0;
        tick();
        chk("mr_retry_addr", 32'(ram_addr), 32'h123);
        chk("mr_retry_ack1", 32'(cpu_ack), 32'd0);
        tick();
        chk("mr_retry_ack2", 32'(cpu_ack), 32'd0);
        tick();
        chk("mr_retry_ack3", 32'(cpu_ack), 32'd1);
        chk("mr_retry_data", 32'(cpu_rdata), 32'h41);
        last_cpu = 8'h41;
        cpu_req  = 1'b0;
        tick();
        m_starve = 0;

        // Starvation: both requesters saturate the port.
        seq = "";
        for (int i = 0; i < 10; i++) begin
            round(1'b1, got);
            seq = {seq, got ? "C" : "D"};
        end
        checks++;
        assert (seq == "DDDDCDDDDC") else begin
            errors++;
            $error("FAIL starve_order observed %s expected DDDDCDDDDC", seq);
        end

        // Random mixed traffic.
        for (int i = 0; i < 150; i++) round(1'b0, got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port arbiter for the video character RAM. It sits between the 6502 CPU bus and the display character fetcher inside the uk101 core. Each requester gets a level request / one-cycle acknowledge handshake. The display fetcher has priority, and a starvation counter guarantees the CPU bounded latency.

## Interface
Parameters:
- ADDR_W, 11, VRAM address width (2 KB, 64x32 characters)
- DATA_W, 8, data width
- CPU_STARVE_MAX, 4, consecutive display grants tolerated while the CPU waits (1..15)

Ports:
- clk  in  1  system clock (the 50 MHz core clock)
- n_reset  in  1  reset; synchronous and active-low
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  CPU read data; valid with cpu_ack and held until the next CPU read ack
- disp_req  in  1  display read request, held until disp_ack
- disp_addr  in  ADDR_W  display read address
- disp_ack  out  1  one-cycle completion pulse
- disp_rdata  out  DATA_W  display read data; valid with disp_ack and held until the next display ack
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_we  out  1  RAM write strobe (registered)
- ram_rdata  in  DATA_W  RAM read data; synchronous RAM, valid the cycle after ram_addr is presented
- busy  out  1  high when the state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. A register records the owner of the current access (DISP or CPU).
- **IDLE** samples both requests:
  - If only one is high, that requester wins.
  - If both are high, DISP wins unless starve_cnt == CPU_STARVE_MAX, in which case CPU wins.
  - The winner's addr, we and wdata are latched into the ram_* registers. Next state is ISSUE.
  - Display accesses are always reads; ram_we stays 0 for DISP.
- **ISSUE**: ram_addr is valid. For a CPU write, ram_we = 1 for this cycle only. Next state is WAIT for a read, DONE for a write.
- **WAIT**: ram_rdata is valid and is registered into the owner's rdata output. Next state is DONE.
- **DONE**: the owner's ack = 1 for this cycle only. Next state is IDLE.
- **Request sampling after an access**:
  - Requests are ignored in ISSUE, WAIT and DONE.
  - A req still high in the cycle after ack is treated as a new request.
- **starve_cnt** (4 bits):
  - Increments on each DISP grant made while cpu_req = 1, saturating at CPU_STARVE_MAX.
  - Clears on a CPU grant.
  - Clears in any IDLE cycle where cpu_req = 0.
- ram_addr and ram_wdata hold their last values between accesses. ram_we is 0 outside a write ISSUE cycle.
- **Reset**:
  - All outputs go to 0 and the FSM returns to IDLE. starve_cnt = 0, rdata registers = 0.
  - Reset mid-access aborts the access and issues no ack. ram_we is 0 from the first clock edge with n_reset low.

## Timing
- In all timings below, N is the IDLE cycle in which the winning req is sampled.
- **Read latency**: ram_addr is valid in N+1. rdata is captured at the end of N+2. ack and rdata are visible in N+3.
- **Write latency**: ram_we, ram_addr and ram_wdata are valid in N+1. ack is visible in N+2.
- **Throughput**: one read per 4 cycles and one write per 3 cycles. This is well inside the display budget of 48 clk per character (ce_pix = clk/6, 8 pixels per character).
- **Worst-case CPU wait** with continuous display traffic: CPU_STARVE_MAX x 4 cycles of display reads, plus its own access.
- busy is high from N+1 through the ack cycle inclusive.

## Test plan
- **Reset**: hold n_reset = 0 for 3 cycles with both reqs high. Required: cpu_ack = disp_ack = ram_we = busy = 0, all data outputs 0, and no grant until the first IDLE after release.
- **Display read**: RAM[0x123] = 0x41, disp_req pulsed at N. Required: ram_addr = 0x123 in N+1, disp_ack = 1 only in N+3, disp_rdata = 0x41, ram_we never 1.
- **CPU write then read**: write 0x5A to 0x7FF at N. Required: ram_we = 1 only in N+1 with addr 0x7FF and data 0x5A, and cpu_ack in N+2. A following read of 0x7FF returns cpu_rdata = 0x5A with cpu_ack 3 cycles after its IDLE sample.
- **Simultaneous requests**: both requests first sampled at N with starve_cnt = 0, CPU write, and disp_req dropped after its ack. Required: disp_ack in N+3, IDLE in N+4, ram_we in N+5, cpu_ack in N+6.
- **Starvation**: disp_req held high continuously with new addresses, cpu_req held high (reads), CPU_STARVE_MAX = 4. Required grant order: D, D, D, D, C, D, D, D, D, C, with starve_cnt returning to 0 after each C.
- **Reset mid-read**: n_reset = 0 during the ISSUE cycle of a CPU read. Required: no cpu_ack ever, cpu_rdata = 0, FSM in IDLE, and the CPU retry after release completes normally.
